// File: rtl/mealy_seq_ctrl.sv
// Symbol-buffer sequencer that steps an external 2-bit-input Mealy FSM and captures its output per step.
// Optional replay of the loaded buffer is enabled with the SEQ_CTRL_LOOP_EN macro (adds the loop input).
module mealy_seq_ctrl #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [1:0]       wr_sym,
    output logic             wr_ready,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fsm_rst,
    output logic             fsm_en,
    output logic [1:0]       fsm_in,
    input  logic             fsm_out,
`ifdef SEQ_CTRL_LOOP_EN
    input  logic             loop,
`endif
    output logic [DEPTH-1:0] res_bits,
    output logic [CW-1:0]    res_ones,
    output logic [CW-1:0]    res_len
);

    localparam int IW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [CW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             rst_hold_q;
    logic [DEPTH-1:0] res_bits_q, res_bits_d;
    logic [CW-1:0]    res_ones_q, res_ones_d;
    logic [CW-1:0]    res_len_q, res_len_d;
    logic [1:0]       buf_q [DEPTH];
    logic             wr_acc;
    logic             step;
    logic             loop_en;
    logic [CW-1:0]    eff_len;

`ifdef SEQ_CTRL_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        len_d      = len_q;
        idx_d      = idx_q;
        tick_d     = tick_q;
        res_bits_d = res_bits_q;
        res_ones_d = res_ones_q;
        res_len_d  = res_len_q;
        wr_acc     = 1'b0;
        step       = 1'b0;
        eff_len    = wcnt_q;
        case (state_q)
            IDLE: begin
                wr_acc  = wr_valid && (wcnt_q < CW'(DEPTH));
                eff_len = wcnt_q + CW'(wr_acc);
                if (wr_acc) wcnt_d = eff_len;
                // A start in the same cycle as a write includes that write in the run.
                if (start && (eff_len != '0)) begin
                    len_d   = eff_len;
                    state_d = CLR;
                end
            end
            CLR: begin
                res_bits_d = '0;
                res_ones_d = '0;
                res_len_d  = len_q;
                idx_d      = '0;
                tick_d     = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (tick_q == TW'(TICK_DIV - 1)) begin
                    step              = 1'b1;
                    res_bits_d[idx_q] = fsm_out;
                    res_ones_d        = res_ones_q + CW'(fsm_out);
                    tick_d            = '0;
                    idx_d             = idx_q + IW'(1);
                    if (CW'(idx_q) == len_q - CW'(1)) state_d = DONE;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DONE: begin
                if (loop_en) begin
                    state_d = CLR;
                end else begin
                    wcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            tick_q     <= '0;
            rst_hold_q <= 1'b1;
            res_bits_q <= '0;
            res_ones_q <= '0;
            res_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
            rst_hold_q <= 1'b0;
            res_bits_q <= res_bits_d;
            res_ones_q <= res_ones_d;
            res_len_q  <= res_len_d;
        end
    end

    // Buffer is pure data; stale entries are never read because wcnt bounds every run.
    always_ff @(posedge clk) begin
        if (wr_acc) buf_q[wcnt_q[IW-1:0]] <= wr_sym;
    end

    assign wr_ready = (state_q == IDLE) && (wcnt_q < CW'(DEPTH));
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign fsm_rst  = rst_hold_q || (state_q == CLR);
    assign fsm_en   = step;
    assign fsm_in   = (state_q == RUN) ? buf_q[idx_q] : 2'b00;
    assign res_bits = res_bits_q;
    assign res_ones = res_ones_q;
    assign res_len  = res_len_q;

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Bench for mealy_seq_ctrl: two instances (TICK_DIV 4 and 1) share stimulus and are checked against a run model.
// The loop scenario is compiled only when SEQ_CTRL_LOOP_EN is defined.
module tb_mealy_seq_ctrl;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_valid;
    logic [1:0] wr_sym;
    logic       start;
    logic       loop;

    logic [1:0]            wr_ready_v, busy_v, done_v, fsm_rst_v, fsm_en_v, fsm_out_v, fs_q;
    logic [1:0][1:0]       fsm_in_v;
    logic [1:0][DEPTH-1:0] res_bits_v;
    logic [1:0][CW-1:0]    res_ones_v, res_len_v;

    int vec = 0;
    int errs = 0;
    logic [1:0] mq[$];

    mealy_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_sym(wr_sym), .wr_ready(wr_ready_v[0]),
        .start(start), .busy(busy_v[0]), .done(done_v[0]), .fsm_rst(fsm_rst_v[0]), .fsm_en(fsm_en_v[0]),
        .fsm_in(fsm_in_v[0]), .fsm_out(fsm_out_v[0]),
`ifdef SEQ_CTRL_LOOP_EN
        .loop(loop),
`endif
        .res_bits(res_bits_v[0]), .res_ones(res_ones_v[0]), .res_len(res_len_v[0]));

    mealy_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_sym(wr_sym), .wr_ready(wr_ready_v[1]),
        .start(start), .busy(busy_v[1]), .done(done_v[1]), .fsm_rst(fsm_rst_v[1]), .fsm_en(fsm_en_v[1]),
        .fsm_in(fsm_in_v[1]), .fsm_out(fsm_out_v[1]),
`ifdef SEQ_CTRL_LOOP_EN
        .loop(loop),
`endif
        .res_bits(res_bits_v[1]), .res_ones(res_ones_v[1]), .res_len(res_len_v[1]));

    // Stand-in Mealy FSM: state flips on each stepped symbol 3; output is (in==1) xor state.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (fsm_rst_v[j]) fs_q[j] <= 1'b0;
            else if (fsm_en_v[j] && fsm_in_v[j] == 2'd3) fs_q[j] <= ~fs_q[j];
        end
    end

    always_comb begin
        fsm_out_v = '0;
        for (int j = 0; j < 2; j++) fsm_out_v[j] = (fsm_in_v[j] == 2'd1) ^ fs_q[j];
    end

    function automatic int tdiv(input int j);
        return (j == 0) ? 4 : 1;
    endfunction

    function automatic logic [DEPTH-1:0] exp_bits(input int len);
        logic [DEPTH-1:0] b = '0;
        logic par = 1'b0;
        for (int i = 0; i < len; i++) begin
            b[i] = (mq[i] == 2'd1) ^ par;
            if (mq[i] == 2'd3) par = ~par;
        end
        return b;
    endfunction

    function automatic int exp_ones(input int len);
        logic [DEPTH-1:0] b = exp_bits(len);
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(b[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sym(input logic [1:0] s, input bit with_start);
        logic exp_rdy = (mq.size() < DEPTH);
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (wr_ready_v[j] !== exp_rdy) begin
                errs++;
                $display("FAIL wr_ready inst%0d: got %b want %b", j, wr_ready_v[j], exp_rdy);
            end
        end
        wr_valid = 1'b1; wr_sym = s; start = with_start;
        tick();
        wr_valid = 1'b0; start = 1'b0;
        if (exp_rdy) mq.push_back(s);
    endtask

    // Walks a whole run cycle by cycle; cycle n is the n-th cycle after the start request.
    task automatic run_and_check(input bit started, input bit poke);
        int len = mq.size();
        int last = 2 + len * 4;
        if (!started) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int n = 1; n <= last + 1; n++) begin
            for (int j = 0; j < 2; j++) begin
                int t = tdiv(j);
                int end_c = 2 + len * t;
                bit run = (n >= 2) && (n < end_c);
                logic e_busy = (n <= end_c);
                logic e_done = (n == end_c);
                logic e_rst = (n == 1);
                logic e_en = run && ((n - 1) % t == 0);
                logic [1:0] e_in = run ? mq[(n - 2) / t] : 2'd0;
                vec++;
                if (busy_v[j] !== e_busy || done_v[j] !== e_done || fsm_rst_v[j] !== e_rst ||
                    fsm_en_v[j] !== e_en || fsm_in_v[j] !== e_in || wr_ready_v[j] !== !e_busy) begin
                    errs++;
                    $display("FAIL run_cycle inst%0d cyc%0d: got busy%b done%b rst%b en%b in%0d rdy%b want busy%b done%b rst%b en%b in%0d rdy%b",
                             j, n, busy_v[j], done_v[j], fsm_rst_v[j], fsm_en_v[j], fsm_in_v[j], wr_ready_v[j],
                             e_busy, e_done, e_rst, e_en, e_in, !e_busy);
                end
            end
            if (poke && n == 2) begin wr_valid = 1'b1; wr_sym = 2'd1; start = 1'b1; end
            if (n == 3) begin wr_valid = 1'b0; start = 1'b0; end
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (res_bits_v[j] !== exp_bits(len) || res_ones_v[j] !== CW'(exp_ones(len)) ||
                res_len_v[j] !== CW'(len)) begin
                errs++;
                $display("FAIL results inst%0d: got bits %b ones %0d len %0d want bits %b ones %0d len %0d",
                         j, res_bits_v[j], res_ones_v[j], res_len_v[j], exp_bits(len), exp_ones(len), len);
            end
        end
        mq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_sym = 2'd0; start = 1'b0; loop = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (wr_ready_v[j] !== 1'b1 || busy_v[j] !== 1'b0 || fsm_rst_v[j] !== 1'b1 ||
                fsm_en_v[j] !== 1'b0 || res_bits_v[j] !== '0 || res_len_v[j] !== '0) begin
                errs++;
                $display("FAIL reset_vals inst%0d: got rdy%b busy%b rst%b en%b bits%h len%0d want 1 0 1 0 0 0",
                         j, wr_ready_v[j], busy_v[j], fsm_rst_v[j], fsm_en_v[j], res_bits_v[j], res_len_v[j]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (fsm_rst_v[j] !== 1'b0) begin
                errs++;
                $display("FAIL rst_release inst%0d: got fsm_rst %b want 0", j, fsm_rst_v[j]);
            end
        end
    endtask

    task automatic test_basic();
        write_sym(2'd0, 0); write_sym(2'd1, 0); write_sym(2'd2, 0); write_sym(2'd3, 0);
        run_and_check(0, 0);
        vec++;
        if (res_bits_v[0] !== 8'b0000_0010) begin
            errs++;
            $display("FAIL basic_bits: got %b want 00000010", res_bits_v[0]);
        end
    endtask

    task automatic test_full_buffer();
        for (int i = 0; i < DEPTH + 1; i++) write_sym(2'($urandom_range(0, 3)), 0);
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (wr_ready_v[j] !== 1'b0) begin
                errs++;
                $display("FAIL full_ready inst%0d: got %b want 0", j, wr_ready_v[j]);
            end
        end
        run_and_check(0, 0);
    endtask

    task automatic test_ignored();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < 2; j++) begin
                vec++;
                if (busy_v[j] !== 1'b0) begin
                    errs++;
                    $display("FAIL empty_start inst%0d: got busy %b want 0", j, busy_v[j]);
                end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) write_sym(2'($urandom_range(0, 3)), 0);
        run_and_check(0, 1);
    endtask

    task automatic test_first_write_start();
        write_sym(2'($urandom_range(0, 3)), 1);
        run_and_check(1, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) write_sym(2'($urandom_range(0, 3)), 0);
            run_and_check(0, r[0]);
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 3; i++) write_sym(2'($urandom_range(0, 3)), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #3 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (busy_v[j] !== 1'b0 || wr_ready_v[j] !== 1'b1 || fsm_rst_v[j] !== 1'b1 || done_v[j] !== 1'b0 ||
                fsm_en_v[j] !== 1'b0 || fsm_in_v[j] !== 2'd0 || res_bits_v[j] !== '0 || res_ones_v[j] !== '0) begin
                errs++;
                $display("FAIL midrun_reset inst%0d: got busy%b rdy%b rst%b done%b en%b in%0d bits%h want 0 1 1 0 0 0 0",
                         j, busy_v[j], wr_ready_v[j], fsm_rst_v[j], done_v[j], fsm_en_v[j], fsm_in_v[j], res_bits_v[j]);
            end
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (busy_v[j] !== 1'b0 || fsm_rst_v[j] !== 1'b0) begin
                errs++;
                $display("FAIL buffer_discard inst%0d: got busy %b rst %b want 0 0", j, busy_v[j], fsm_rst_v[j]);
            end
        end
    endtask

`ifdef SEQ_CTRL_LOOP_EN
    task automatic test_loop();
        int cyc;
        write_sym(2'd1, 0); write_sym(2'd3, 0);
        loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            for (int j = 0; j < 2; j++) begin
                int t = tdiv(j);
                int first = 2 + 2 * t;
                logic e_done = (n >= first) && ((n - first) % (2 * t + 2) == 0);
                vec++;
                if (done_v[j] !== e_done || busy_v[j] !== 1'b1) begin
                    errs++;
                    $display("FAIL loop_done inst%0d cyc%0d: got done %b busy %b want %b 1", j, n, done_v[j], busy_v[j], e_done);
                end
            end
            tick();
        end
        loop = 1'b0;
        cyc = 0;
        while ((busy_v !== 2'b00) && cyc < 30) begin
            tick();
            cyc++;
        end
        for (int j = 0; j < 2; j++) begin
            vec++;
            if (busy_v[j] !== 1'b0 || res_len_v[j] !== CW'(2) || res_bits_v[j] !== exp_bits(2)) begin
                errs++;
                $display("FAIL loop_exit inst%0d: got busy %b len %0d bits %b want 0 2 %b",
                         j, busy_v[j], res_len_v[j], res_bits_v[j], exp_bits(2));
            end
        end
        mq.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_buffer();
        test_ignored();
        test_first_write_start();
        test_random();
        test_reset_midrun();
`ifdef SEQ_CTRL_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
